// File: rtl/sha256_job_dispatcher.sv
// sha256_job_dispatcher
//
// Host-side initiator for a SHA256 mining node on the ring. A 96-bit host
// job is latched, sent to node id_p as two addressed flits (JOB_HI, then
// JOB_LO), and the dispatcher then waits for that node's RESULT flit. The
// nonce/found pair, or a timeout indication, is held for the host until
// result_yumi_i.
//
// Optional feature macro: SHA256_DISPATCH_TIMEOUT_EN
//   defined   - a saturating 32-bit wait counter ends WAIT_RESULT after
//               timeout_p cycles with a timeout result.
//   undefined - no counter; WAIT_RESULT ends only on a matching result,
//               result_timeout_o is tied low and timeout_p is unused.
//
// Flit layout: [79:72] node id, [71:64] type, [63:0] payload.
//
// Ports
//   clk_i, reset_n_i            clock (rising edge), async active-low reset
//   job_v_i, job_i, job_ready_o host job handshake ({message[63:0], target[31:0]})
//   v_o, data_o, yumi_i         outgoing ring flit (valid / data / consumed)
//   v_i, data_i, ready_o        incoming ring flit (valid / data / taken)
//   result_v_o, result_nonce_o, result_found_o, result_timeout_o,
//   result_yumi_i               result to host and its consume strobe
//   busy_o                      high whenever the dispatcher is not idle
module sha256_job_dispatcher #(
    parameter int unsigned ring_width_p = 80,
    parameter logic [7:0]  id_p         = 8'h00,
    parameter logic [31:0] timeout_p    = 32'hFFFF_FFFF
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    job_v_i,
    input  logic [95:0]             job_i,
    output logic                    job_ready_o,
    output logic                    v_o,
    output logic [ring_width_p-1:0] data_o,
    input  logic                    yumi_i,
    input  logic                    v_i,
    input  logic [ring_width_p-1:0] data_i,
    output logic                    ready_o,
    output logic                    result_v_o,
    output logic [31:0]             result_nonce_o,
    output logic                    result_found_o,
    output logic                    result_timeout_o,
    input  logic                    result_yumi_i,
    output logic                    busy_o
);

    localparam logic [7:0] type_job_hi_c = 8'h01;
    localparam logic [7:0] type_job_lo_c = 8'h02;
    localparam logic [7:0] type_result_c = 8'h81;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SEND_HI     = 3'd1,
        SEND_LO     = 3'd2,
        WAIT_RESULT = 3'd3,
        HOLD_RESULT = 3'd4
    } state_t;

    state_t      state_r;
    logic [31:0] target_r;
    logic        match_s;
    logic        unused_s;

    // A flit is a usable result only if it is taken this cycle and is a
    // RESULT addressed to our node; anything else taken is dropped.
    assign match_s = v_i && ready_o
                  && (data_i[79:72] == id_p)
                  && (data_i[71:64] == type_result_c);

`ifdef SHA256_DISPATCH_TIMEOUT_EN
    logic [31:0] wait_cnt_r;
    logic        timeout_hit_s;

    // Counter value k means the (k+1)-th cycle in WAIT_RESULT, so the
    // result appears exactly timeout_p cycles after entry.
    assign timeout_hit_s = (wait_cnt_r == (timeout_p - 32'd1));
    assign unused_s      = ^data_i[63:33];
`else
    assign unused_s      = ^{data_i[63:33], timeout_p};
    assign result_timeout_o = 1'b0;
`endif

    // Dispatcher FSM; every output is registered and set for the state
    // being entered so it is valid in the first cycle of that state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r        <= IDLE;
            target_r       <= 32'h0;
            job_ready_o    <= 1'b1;
            v_o            <= 1'b0;
            data_o         <= 80'h0;
            ready_o        <= 1'b1;
            result_v_o     <= 1'b0;
            result_nonce_o <= 32'h0;
            result_found_o <= 1'b0;
            busy_o         <= 1'b0;
`ifdef SHA256_DISPATCH_TIMEOUT_EN
            result_timeout_o <= 1'b0;
            wait_cnt_r       <= 32'h0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (job_v_i && job_ready_o) begin
                        // Only the target is kept; the message goes straight
                        // into the JOB_HI flit register.
                        state_r     <= SEND_HI;
                        target_r    <= job_i[31:0];
                        job_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        v_o         <= 1'b1;
                        data_o      <= {id_p, type_job_hi_c, job_i[95:32]};
                    end
                end
                SEND_HI: begin
                    if (yumi_i) begin
                        state_r <= SEND_LO;
                        data_o  <= {id_p, type_job_lo_c, 32'h0, target_r};
                    end
                end
                SEND_LO: begin
                    if (yumi_i) begin
                        state_r <= WAIT_RESULT;
                        v_o     <= 1'b0;
                        data_o  <= 80'h0;
`ifdef SHA256_DISPATCH_TIMEOUT_EN
                        wait_cnt_r <= 32'h0;
`endif
                    end
                end
                WAIT_RESULT: begin
                    // A matching result has priority over a same-cycle timeout.
                    if (match_s) begin
                        state_r        <= HOLD_RESULT;
                        ready_o        <= 1'b0;
                        result_v_o     <= 1'b1;
                        result_nonce_o <= data_i[31:0];
                        result_found_o <= data_i[32];
`ifdef SHA256_DISPATCH_TIMEOUT_EN
                        result_timeout_o <= 1'b0;
                    end else if (timeout_hit_s) begin
                        state_r          <= HOLD_RESULT;
                        ready_o          <= 1'b0;
                        result_v_o       <= 1'b1;
                        result_nonce_o   <= 32'h0;
                        result_found_o   <= 1'b0;
                        result_timeout_o <= 1'b1;
                    end else if (wait_cnt_r != 32'hFFFF_FFFF) begin
                        wait_cnt_r <= wait_cnt_r + 32'd1;
`endif
                    end
                end
                HOLD_RESULT: begin
                    if (result_yumi_i) begin
                        state_r        <= IDLE;
                        ready_o        <= 1'b1;
                        job_ready_o    <= 1'b1;
                        busy_o         <= 1'b0;
                        result_v_o     <= 1'b0;
                        result_nonce_o <= 32'h0;
                        result_found_o <= 1'b0;
`ifdef SHA256_DISPATCH_TIMEOUT_EN
                        result_timeout_o <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_r        <= IDLE;
                    job_ready_o    <= 1'b1;
                    v_o            <= 1'b0;
                    data_o         <= 80'h0;
                    ready_o        <= 1'b1;
                    result_v_o     <= 1'b0;
                    result_nonce_o <= 32'h0;
                    result_found_o <= 1'b0;
                    busy_o         <= 1'b0;
`ifdef SHA256_DISPATCH_TIMEOUT_EN
                    result_timeout_o <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_job_dispatcher.sv
// Self-checking bench for sha256_job_dispatcher: directed scenarios with
// hand-computed expectations, then randomized traffic compared every cycle
// against a queue-based transaction model.
module tb_sha256_job_dispatcher;

    localparam logic [7:0]  ID = 8'h03;
    localparam logic [31:0] TO = 32'd16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        job_v = 1'b0;
    logic [95:0] job = 96'h0;
    logic        job_ready;
    logic        v_out;
    logic [79:0] data_out;
    logic        yumi = 1'b0;
    logic        v_in = 1'b0;
    logic [79:0] data_in = 80'h0;
    logic        ready;
    logic        result_v;
    logic [31:0] result_nonce;
    logic        result_found;
    logic        result_timeout;
    logic        result_yumi = 1'b0;
    logic        busy;

    int unsigned total_cnt = 0;
    int unsigned pass_cnt  = 0;
    int unsigned nflits    = 0;
    bit          chk_en    = 1'b0;

    always #5 clk = ~clk;

    sha256_job_dispatcher #(
        .ring_width_p(80),
        .id_p        (ID),
        .timeout_p   (TO)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .job_v_i         (job_v),
        .job_i           (job),
        .job_ready_o     (job_ready),
        .v_o             (v_out),
        .data_o          (data_out),
        .yumi_i          (yumi),
        .v_i             (v_in),
        .data_i          (data_in),
        .ready_o         (ready),
        .result_v_o      (result_v),
        .result_nonce_o  (result_nonce),
        .result_found_o  (result_found),
        .result_timeout_o(result_timeout),
        .result_yumi_i   (result_yumi),
        .busy_o          (busy)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic chk80(input string name, input logic [79:0] act, input logic [79:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    // ---------------- transaction model ----------------
    // Pending flits to send, whether a result is awaited, and the held result.
    logic [79:0] m_q[$];
    bit          m_wait;
    bit          m_res;
    bit          m_idle;
    int unsigned m_age;
    logic [31:0] m_nonce;
    logic        m_found;
    logic        m_to;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_wait = 1'b0; m_res = 1'b0; m_age = 0;
            m_nonce = 32'h0; m_found = 1'b0; m_to = 1'b0;
        end else begin
            m_idle = (m_q.size() == 0) && !m_wait && !m_res;
            if (m_idle) begin
                if (job_v) begin
                    m_q.push_back({ID, 8'h01, job[95:32]});
                    m_q.push_back({ID, 8'h02, 32'h0, job[31:0]});
                end
            end else if (m_q.size() != 0) begin
                if (yumi) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_wait = 1'b1;
                        m_age  = 0;
                    end
                end
            end else if (m_wait) begin
                if (v_in && data_in[79:72] == ID && data_in[71:64] == 8'h81) begin
                    m_res = 1'b1; m_wait = 1'b0;
                    m_nonce = data_in[31:0]; m_found = data_in[32]; m_to = 1'b0;
                end
`ifdef SHA256_DISPATCH_TIMEOUT_EN
                else if (m_age + 1 == TO) begin
                    m_res = 1'b1; m_wait = 1'b0;
                    m_nonce = 32'h0; m_found = 1'b0; m_to = 1'b1;
                end
`endif
                else begin
                    m_age++;
                end
            end else if (result_yumi) begin
                m_res = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (v_out && yumi) nflits++;
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk1("job_ready", job_ready, (m_q.size() == 0) && !m_wait && !m_res);
            chk1("busy", busy, !((m_q.size() == 0) && !m_wait && !m_res));
            chk1("v_o", v_out, m_q.size() != 0);
            if (m_q.size() != 0) chk80("data_o", data_out, m_q[0]);
            chk1("ready_o", ready, !m_res);
            chk1("result_v", result_v, m_res);
            if (m_res) begin
                chk32("result_nonce", result_nonce, m_nonce);
                chk1("result_found", result_found, m_found);
                chk1("result_timeout", result_timeout, m_to);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_job_ready"}, job_ready, 1'b1);
        chk1({tag, "_ready"}, ready, 1'b1);
        chk1({tag, "_v_o"}, v_out, 1'b0);
        chk80({tag, "_data_o"}, data_out, 80'h0);
        chk1({tag, "_result_v"}, result_v, 1'b0);
        chk32({tag, "_nonce"}, result_nonce, 32'h0);
        chk1({tag, "_found"}, result_found, 1'b0);
        chk1({tag, "_timeout"}, result_timeout, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
    endtask

    // Present a job with yumi held high; returns at the first WAIT_RESULT cycle.
    task automatic send_job(input logic [95:0] j);
        job_v = 1'b1; job = j; yumi = 1'b1;
        step();
        job_v = 1'b0;
        step();
        step();
        yumi = 1'b0;
    endtask

    task automatic release_result();
        result_yumi = 1'b1;
        step();
        result_yumi = 1'b0;
    endtask

    int unsigned n;
    int unsigned sent0;

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Basic job and result
        job_v = 1'b1; job = 96'h0123456789ABCDEF_0000FFFF; yumi = 1'b1;
        step();
        job_v = 1'b0;
        chk1("hi_valid", v_out, 1'b1);
        chk80("hi_flit", data_out, {8'h03, 8'h01, 64'h0123456789ABCDEF});
        step();
        chk80("lo_flit", data_out, {8'h03, 8'h02, 64'h0000_0000_0000_FFFF});
        step();
        yumi = 1'b0;
        chk1("wait_no_v", v_out, 1'b0);
        v_in = 1'b1; data_in = {8'h03, 8'h81, 31'h0, 1'b1, 32'hDEADBEEF};
        step();
        v_in = 1'b0;
        chk1("res_v", result_v, 1'b1);
        chk32("res_nonce", result_nonce, 32'hDEADBEEF);
        chk1("res_found", result_found, 1'b1);
        chk1("res_timeout", result_timeout, 1'b0);

        // Host stalls the result
        repeat (10) begin
            step();
            chk32("hold_nonce", result_nonce, 32'hDEADBEEF);
            chk1("hold_ready", ready, 1'b0);
            chk1("hold_job_ready", job_ready, 1'b0);
        end
        result_yumi = 1'b1; job_v = 1'b1; job = 96'hFEDCBA98_76543210_11223344;
        step();
        result_yumi = 1'b0;
        chk1("post_yumi_job_ready", job_ready, 1'b1);
        chk1("no_accept_in_yumi", v_out, 1'b0);
        step();
        job_v = 1'b0;
        chk1("accept_next", v_out, 1'b1);

        // Backpressure on both flits
        sent0 = nflits;
        repeat (5) begin
            step();
            chk80("bp_hi", data_out, {8'h03, 8'h01, 64'hFEDCBA98_76543210});
        end
        yumi = 1'b1; step(); yumi = 1'b0;
        repeat (5) begin
            step();
            chk80("bp_lo", data_out, {8'h03, 8'h02, 64'h0000_0000_1122_3344});
        end
        yumi = 1'b1; step(); yumi = 1'b0;
        repeat (3) step();
        chk32("bp_flit_count", nflits - sent0, 32'd2);

        // Foreign flits while waiting
        send_job(96'h1);
        v_in = 1'b1; data_in = {8'h04, 8'h81, 64'h1_0000_0001};
        chk1("foreign_id_ready", ready, 1'b1);
        step();
        chk1("foreign_id_no_res", result_v, 1'b0);
        data_in = {8'h03, 8'h01, 64'h1_0000_0002};
        chk1("foreign_type_ready", ready, 1'b1);
        step();
        chk1("foreign_type_no_res", result_v, 1'b0);
        data_in = {8'h03, 8'h81, 64'h0000_0000_1234_5678};
        step();
        v_in = 1'b0;
        chk32("after_foreign_nonce", result_nonce, 32'h12345678);
        chk1("after_foreign_found", result_found, 1'b0);
        release_result();

`ifdef SHA256_DISPATCH_TIMEOUT_EN
        // Timeout with no result
        send_job(96'h2);
        n = 0;
        while (!result_v && n < 40) begin
            step();
            n++;
        end
        chk32("timeout_latency", n, 32'd16);
        chk1("timeout_flag", result_timeout, 1'b1);
        chk32("timeout_nonce", result_nonce, 32'h0);
        chk1("timeout_found", result_found, 1'b0);
        release_result();

        // Result in the timeout cycle wins
        send_job(96'h3);
        repeat (15) step();
        v_in = 1'b1; data_in = {8'h03, 8'h81, 31'h0, 1'b1, 32'hCAFEF00D};
        step();
        v_in = 1'b0;
        chk1("race_res_v", result_v, 1'b1);
        chk1("race_timeout", result_timeout, 1'b0);
        chk32("race_nonce", result_nonce, 32'hCAFEF00D);
        release_result();
`else
        // Without the timeout path the wait never ends on its own
        send_job(96'h2);
        repeat (40) step();
        chk1("no_timeout_res_v", result_v, 1'b0);
        v_in = 1'b1; data_in = {8'h03, 8'h81, 31'h0, 1'b1, 32'h0BADF00D};
        step();
        v_in = 1'b0;
        chk32("late_nonce", result_nonce, 32'h0BADF00D);
        chk1("late_timeout", result_timeout, 1'b0);
        release_result();
`endif

        // Reset during SEND_LO
        job_v = 1'b1; job = 96'h5; yumi = 1'b1;
        step();
        job_v = 1'b0;
        step();
        chk1("pre_reset_v", v_out, 1'b1);
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("async_reset");
        step();
        step();
        reset_n = 1'b1;
        yumi = 1'b0;
        step();
        chk1("no_stray_v", v_out, 1'b0);
        job_v = 1'b1; job = 96'hAAAA5555_12345678_9ABCDEF0; yumi = 1'b1;
        step();
        job_v = 1'b0;
        chk80("post_reset_hi", data_out, {8'h03, 8'h01, 64'hAAAA5555_12345678});
        step();
        chk80("post_reset_lo", data_out, {8'h03, 8'h02, 64'h0000_0000_9ABC_DEF0});
        step();
        yumi = 1'b0;
        v_in = 1'b1; data_in = {8'h03, 8'h81, 64'h0000_0001_0000_0077};
        step();
        v_in = 1'b0;
        chk32("post_reset_nonce", result_nonce, 32'h77);
        release_result();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            job_v       = ($urandom_range(0, 3) == 0);
            job         = {$urandom, $urandom, $urandom};
            yumi        = ($urandom_range(0, 2) != 0);
            result_yumi = ($urandom_range(0, 3) == 0);
            v_in        = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 3))
                0: data_in = {ID, 8'h81, $urandom, $urandom};
                1: data_in = {8'(ID + 8'd1 + 8'($urandom_range(0, 253))), 8'h81, $urandom, $urandom};
                2: data_in = {ID, 8'(8'h01 + 8'($urandom_range(0, 1))), $urandom, $urandom};
                default: data_in = {16'($urandom), $urandom, $urandom};
            endcase
            step();
        end
        job_v = 1'b0; yumi = 1'b0; v_in = 1'b0; result_yumi = 1'b0;
        step();
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
